aluout_trace_buffer: RTL
========================

Name: aluout_trace_buffer

Overview:
- Capture-side companion to the pipelined_4stage core: the consumer end of the core's aluout result bus.
- Samples aluout on each clock in which capture is enabled and stores each sample with a cycle stamp in a circular buffer.
- A valid/ready read port lets a bench or debug unit drain the entries in order.
- Used for result tracing and self-checking of pipeline runs.

Parameters:
DATA_W, 32, width of the captured aluout value
DEPTH, 16, number of buffer entries; must be a power of 2, ≥2
ADDR_W, 4, log2(DEPTH)
STOP_ON_FULL, 1, 1 = freeze capture after the first dropped sample; 0 = keep trying, drop while full

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset; synchronous, active-high
aluout_in  input  DATA_W  result bus from the core
cap_en  input  1  capture enable level
cap_mode  input  1  0 = sample every cycle; 1 = sample only when value differs from last stored sample
rd_ready  input  1  consumer accepts the head entry
clr_ovf  input  1  clears the sticky overflow flag
rd_valid  output  1  head entry available (= !empty)
rd_data  output  DATA_W  head entry value (show-ahead)
rd_stamp  output  16  cycle stamp of the head entry
count  output  ADDR_W+1  entries held, 0..DEPTH
full  output  1  count == DEPTH
empty  output  1  count == 0
overflow  output  1  sticky: a sample was dropped
state  output  2  FSM state: 0 IDLE, 1 CAPTURE, 2 FROZEN

Behaviour:
- All state updates occur on the rising edge of clk. rst is synchronous, active-high, and overrides everything.
- Reset values:
  - state = IDLE
  - count = 0, write pointer = 0, read pointer = 0
  - empty = 1, full = 0, rd_valid = 0, overflow = 0
  - cycle counter = 0, last-sample register = 0, first-sample flag = 1
  - rd_data and rd_stamp are don't-care while rd_valid = 0; the bench must not check them then.
- Cycle counter:
  - 16-bit, increments every non-reset cycle and wraps 0xFFFF→0.
  - The stamp stored with a sample is the counter value in the cycle of capture, before the increment.
  - The first cycle after rst deasserts has stamp 0.
- FSM:
  - IDLE→CAPTURE when cap_en = 1. The IDLE cycle that sees cap_en does not capture. First possible capture is in the first CAPTURE cycle.
  - CAPTURE→IDLE when cap_en = 0. No capture in that cycle.
  - CAPTURE→FROZEN when STOP_ON_FULL = 1 and a capture is attempted while full without a simultaneous pop.
  - FROZEN→IDLE when cap_en = 0. FROZEN never captures. Reads continue in IDLE and FROZEN.
  - Entering CAPTURE sets the first-sample flag.
- Capture attempt in CAPTURE when cap_en = 1 and at least one of these holds:
  - cap_mode = 0
  - the first-sample flag is set
  - aluout_in != last-sample register
- Accepted capture:
  - writes {aluout_in, stamp} at the write pointer and advances it (wraps modulo DEPTH)
  - updates the last-sample register and clears the first-sample flag
- Dropped capture: happens when full and there is no pop in the same cycle.
  - Sets overflow.
  - Does not update the last-sample register.
- Pop:
  - Pop = rd_valid & rd_ready; advances the read pointer (wraps).
  - rd_ready with empty = 1 is ignored.
- Read timing:
  - rd_data and rd_stamp are combinational from the head entry (show-ahead).
  - A sample captured at edge N is visible on rd_valid/rd_data after edge N.
  - Latency is 1 cycle from aluout_in to rd_data when the buffer was empty.
- Simultaneous push and pop:
  - count unchanged.
  - When full, the push is accepted, not dropped.
  - When empty, no pop occurs; push only.
- overflow: set by a drop; cleared by clr_ovf. A drop in the same cycle as clr_ovf takes priority, so overflow stays 1.
- cap_mode may change at any time and takes effect on the current cycle's compare.
- rst asserted mid-capture: all entries are discarded (count = 0), and the FSM returns to IDLE on that edge.

Test Plan:
- Reset then cap_en=1, cap_mode=0, aluout_in = 0x10, 0x11, 0x12 on three cycles, then cap_en=0 → count = 3. Drain with rd_ready=1 → (0x10, s), (0x11, s+1), (0x12, s+2) in order, where s is the stamp of the first CAPTURE cycle. Then empty = 1.
- cap_mode=1, aluout_in held at 0x5 for 4 cycles, then 0x7 for 2 cycles, then 0x5 → exactly 3 entries: 0x5, 0x7, 0x5, with stamps 4 and 2 apart.
- DEPTH=16, STOP_ON_FULL=1, cap_mode=0, no reads for 18 capture cycles → full = 1, count = 16, overflow = 1, state = FROZEN, entries = first 16 values. Then rd_ready=1 → no new captures until cap_en cycles 0→1.
- Buffer full, STOP_ON_FULL=0, rd_ready=1 held, capture continuous → count stays 16, no drops, overflow = 0, output sequence contiguous. Then assert clr_ovf together with a forced drop → overflow remains 1.
- Wrap checks:
  - Run >65536 cycles before capturing → stamp wraps through 0xFFFF→0x0000 correctly.
  - Pointers wrap after 40 push/pop pairs → data order preserved.
- Mid-capture rst with count = 5 → after the edge: count = 0, rd_valid = 0, state = IDLE, overflow = 0, next stamp 0.

Source files
------------

// File: rtl/aluout_trace_buffer.sv
// Circular trace buffer capturing the core's aluout bus with 16-bit cycle stamps.
// Show-ahead valid/ready drain port, sticky overflow, optional freeze on first drop.
module aluout_trace_buffer #(
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 16,
    parameter int ADDR_W       = 4,
    parameter int STOP_ON_FULL = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] aluout_in,
    input  logic              cap_en,
    input  logic              cap_mode,
    input  logic              rd_ready,
    input  logic              clr_ovf,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [15:0]       rd_stamp,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    output logic [1:0]        state
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CAPTURE = 2'd1;
    localparam logic [1:0] S_FROZEN  = 2'd2;

    localparam logic [ADDR_W:0]   LP_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   LP_CNT1  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] LP_PTR1  = ADDR_W'(1);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] r_rptr;
    logic [ADDR_W:0]   r_count;
    logic              r_ovf;
    logic              r_first;
    logic [15:0]       r_cyc;
    logic [DATA_W-1:0] r_last;
    logic [DATA_W-1:0] r_mem_data  [DEPTH];
    logic [15:0]       r_mem_stamp [DEPTH];

    logic       w_empty;
    logic       w_full;
    logic       w_pop;
    logic       w_attempt;
    logic       w_drop;
    logic       w_push;
    logic [1:0] w_state_nxt;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == LP_DEPTH);
    assign w_pop   = !w_empty && rd_ready;

    assign w_attempt = (r_state == S_CAPTURE) && cap_en &&
                       (!cap_mode || r_first || (aluout_in != r_last));

    // A pop in the same cycle frees the slot, so a full buffer still accepts.
    assign w_drop = w_attempt && w_full && !w_pop;
    assign w_push = w_attempt && !w_drop;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (cap_en)
                    w_state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (!cap_en)
                    w_state_nxt = S_IDLE;
                else if (w_drop && (STOP_ON_FULL != 0))
                    w_state_nxt = S_FROZEN;
            end
            S_FROZEN: begin
                if (!cap_en)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_cyc   <= '0;
            r_last  <= '0;
            r_first <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cyc   <= r_cyc + 16'd1;

            if (w_push) begin
                r_wptr  <= r_wptr + LP_PTR1;
                r_last  <= aluout_in;
                r_first <= 1'b0;
            end else if ((r_state == S_IDLE) && cap_en) begin
                r_first <= 1'b1;
            end

            if (w_pop)
                r_rptr <= r_rptr + LP_PTR1;

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + LP_CNT1;
                2'b01:   r_count <= r_count - LP_CNT1;
                default: r_count <= r_count;
            endcase

            // A drop wins over a simultaneous clear.
            if (w_drop)
                r_ovf <= 1'b1;
            else if (clr_ovf)
                r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem_data[r_wptr]  <= aluout_in;
            r_mem_stamp[r_wptr] <= r_cyc;
        end
    end

    assign rd_valid = !w_empty;
    assign rd_data  = r_mem_data[r_rptr];
    assign rd_stamp = r_mem_stamp[r_rptr];
    assign count    = r_count;
    assign full     = w_full;
    assign empty    = w_empty;
    assign overflow = r_ovf;
    assign state    = r_state;

endmodule
